// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - MIPS fetch stage with IF/ID pipeline register
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_shamt,
  output logic [5:0]  id_funct,
  output logic [15:0] id_imm16,
  output logic [25:0] id_jaddr
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        squash_q, squash_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic [31:0] hold_q, hold_d;

  logic        load;
  logic [31:0] load_word;
  logic [31:0] pc_plus4;

  assign pc_plus4       = pc_q + 32'd4;
  assign imem_addr      = pc_q;
  // A request is only offered in FETCH, and never while reset is asserted.
  assign imem_req_valid = rst_n && (state_q == S_FETCH);

  // Next-state: FSM transitions, squash tracking and IF/ID load decision.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    squash_d      = squash_q;
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_plus4_d = id_pc_plus4_q;
    hold_d        = hold_q;
    load          = 1'b0;
    load_word     = imem_rsp_data;

    if (redirect_valid) begin
      // Redirect wins over stall: kill IF/ID, drop any held word, restart at new PC.
      pc_d       = redirect_pc;
      id_valid_d = 1'b0;
      hold_d     = 32'd0;
      unique case (state_q)
        S_FETCH: begin
          if (imem_req_ready) begin
            state_d  = S_WAIT;
            squash_d = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            state_d  = S_FETCH;
            squash_d = 1'b0;
          end else begin
            squash_d = 1'b1;
          end
        end
        S_HOLD: state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (imem_req_ready) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (squash_q) begin
              squash_d = 1'b0;
              state_d  = S_FETCH;
            end else if (!stall) begin
              load    = 1'b1;
              state_d = S_FETCH;
            end else begin
              hold_d  = imem_rsp_data;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            load      = 1'b1;
            load_word = hold_q;
            state_d   = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase

      // IF/ID register: hold on stall, otherwise load or insert a bubble.
      if (!stall) begin
        if (load) begin
          id_valid_d    = 1'b1;
          id_instr_d    = load_word;
          id_pc_plus4_d = pc_plus4;
          pc_d          = pc_plus4;
        end else begin
          id_valid_d = 1'b0;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      squash_q      <= 1'b0;
      id_valid_q    <= 1'b0;
      id_instr_q    <= 32'd0;
      id_pc_plus4_q <= 32'd0;
      hold_q        <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      squash_q      <= squash_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      hold_q        <= hold_d;
    end
  end

  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_opcode   = id_instr_q[31:26];
  assign id_rs       = id_instr_q[25:21];
  assign id_rt       = id_instr_q[20:16];
  assign id_rd       = id_instr_q[15:11];
  assign id_shamt    = id_instr_q[10:6];
  assign id_funct    = id_instr_q[5:0];
  assign id_imm16    = id_instr_q[15:0];
  assign id_jaddr    = id_instr_q[25:0];

endmodule
